cdc_handshake_tx: RTL

Source-side (launch) end of a multi-bit clock-domain crossing that uses a two-phase toggle handshake. It captures a BUS_WIDTH data word in the CLK domain and holds it stable on TX_DATA. It then toggles TX_REQ, and waits for the destination's toggle acknowledge, which it brings back through a NUM_STAGES flop synchronizer. The destination side qualifies TX_DATA with the synchronized TX_REQ toggle; this block guarantees TX_DATA never changes while a transfer is outstanding.

---
 rtl/cdc_handshake_tx_if.sv | 25 ++
 rtl/cdc_handshake_tx.sv | 90 +++++++++
 2 files changed

// File: rtl/cdc_handshake_tx_if.sv
// Launch-side bundle of the two-phase toggle CDC handshake.
// master is the launching block's view; slave is the requester/destination view.
interface cdc_handshake_tx_if #(
  parameter int BUS_WIDTH = 8
);
  logic [BUS_WIDTH-1:0] DATA_IN;
  logic                 DATA_VALID;
  logic                 READY;
  logic [BUS_WIDTH-1:0] TX_DATA;
  logic                 TX_REQ;
  logic                 ACK_ASYNC;
  logic                 DONE;
  logic                 ERR;
  logic                 ERR_CLR;

  modport master (
    input  DATA_IN, DATA_VALID, ACK_ASYNC, ERR_CLR,
    output READY, TX_DATA, TX_REQ, DONE, ERR
  );

  modport slave (
    output DATA_IN, DATA_VALID, ACK_ASYNC, ERR_CLR,
    input  READY, TX_DATA, TX_REQ, DONE, ERR
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source end of a two-phase toggle CDC: holds a word on TX_DATA, toggles TX_REQ,
// and waits for the destination's toggled acknowledge through a flop synchronizer.
module cdc_handshake_tx #(
  parameter int BUS_WIDTH  = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  cdc_handshake_tx_if.master    bus
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_ACK = 1'b1;

  logic [0:0]            state_q;
  logic [BUS_WIDTH-1:0]  tx_data_q;
  logic                  tx_req_q;
  logic                  ready_q;
  logic                  done_q;
  logic                  err_q;
  logic [NUM_STAGES-1:0] ack_sync_q;
  logic                  ack_sync;
  logic                  err_set;

  // Stage 0 is the only flop that sees ACK_ASYNC; it may go metastable and the
  // remaining stages give it time to resolve before the FSM looks at it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q[0] <= bus.ACK_ASYNC;
      for (int i = 1; i < NUM_STAGES; i++) begin
        ack_sync_q[i] <= ack_sync_q[i-1];
      end
    end
  end

  assign ack_sync = ack_sync_q[NUM_STAGES-1];

  // An acknowledge level that disagrees with the request while idle means the
  // destination toggled without a pending request.
  assign err_set = (state_q == IDLE) && (ack_sync != tx_req_q);

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      tx_data_q <= '0;
      tx_req_q  <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.DATA_VALID) begin
          // Data and request launch on the same edge, so TX_DATA is never
          // younger than the request edge the destination qualifies it with.
          tx_data_q <= bus.DATA_IN;
          tx_req_q  <= ~tx_req_q;
          ready_q   <= 1'b0;
          state_q   <= WAIT_ACK;
        end
      end else begin
        if (ack_sync == tx_req_q) begin
          done_q  <= 1'b1;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end else if (bus.ERR_CLR) begin
      err_q <= 1'b0;
    end
  end

  assign bus.READY   = ready_q;
  assign bus.TX_DATA = tx_data_q;
  assign bus.TX_REQ  = tx_req_q;
  assign bus.DONE    = done_q;
  assign bus.ERR     = err_q;

endmodule
